// File: rtl/debounce_pkg.sv
// Shared state encoding and sizing helper for the push-button debouncer.
package debounce_pkg;

   typedef enum logic [1:0] {
      S_LOW       = 2'd0,
      S_WAIT_HIGH = 2'd1,
      S_HIGH      = 2'd2,
      S_WAIT_LOW  = 2'd3
   } state_t;

   // Tick counter width; a single-tick debounce still needs one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/debounce_sync.sv
// Multi-stage flop synchroniser for a single asynchronous level.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_reg;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
               if (reset) chain_reg[gi] <= 1'b0;
               else       chain_reg[gi] <= d;
            end
         end else begin : g_next
            always_ff @(posedge clk) begin
               if (reset) chain_reg[gi] <= 1'b0;
               else       chain_reg[gi] <= chain_reg[gi-1];
            end
         end
      end
   endgenerate

   assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/debounce_fsm.sv
// Button debouncer: qualifies the synchronised level over STABLE_TICKS timer
// ticks and emits a clean level, edge pulses and a press toggle.
import debounce_pkg::*;

module debounce_fsm #(
   parameter int STABLE_TICKS = 4,
   parameter int SYNC_STAGES  = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   input  logic tick,
   output logic tmr_en,
   output logic db_level,
   output logic db_rise,
   output logic db_fall,
   output logic toggle_out
);

   localparam int CNT_W = cnt_width(STABLE_TICKS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   logic             btn_s;
   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             level_reg, level_next;
   logic             rise_reg, rise_next;
   logic             fall_reg, fall_next;
   logic             toggle_reg, toggle_next;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (btn_in),
      .q     (btn_s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= S_LOW;
         cnt_reg    <= '0;
         level_reg  <= 1'b0;
         rise_reg   <= 1'b0;
         fall_reg   <= 1'b0;
         toggle_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         level_reg  <= level_next;
         rise_reg   <= rise_next;
         fall_reg   <= fall_next;
         toggle_reg <= toggle_next;
      end
   end

   // A reverting input is checked before the tick so a bounce always aborts.
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      level_next  = level_reg;
      rise_next   = 1'b0;
      fall_next   = 1'b0;
      toggle_next = toggle_reg;
      case (state_reg)
         S_LOW: begin
            if (btn_s) begin
               state_next = S_WAIT_HIGH;
               cnt_next   = '0;
            end
         end
         S_WAIT_HIGH: begin
            if (!btn_s) begin
               state_next = S_LOW;
               cnt_next   = '0;
            end else if (tick) begin
               if (cnt_reg == CNT_LAST) begin
                  state_next  = S_HIGH;
                  cnt_next    = '0;
                  level_next  = 1'b1;
                  rise_next   = 1'b1;
                  toggle_next = ~toggle_reg;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         S_HIGH: begin
            if (!btn_s) begin
               state_next = S_WAIT_LOW;
               cnt_next   = '0;
            end
         end
         S_WAIT_LOW: begin
            if (btn_s) begin
               state_next = S_HIGH;
               cnt_next   = '0;
            end else if (tick) begin
               if (cnt_reg == CNT_LAST) begin
                  state_next = S_LOW;
                  cnt_next   = '0;
                  level_next = 1'b0;
                  fall_next  = 1'b1;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         default: begin
            state_next = S_LOW;
            cnt_next   = '0;
         end
      endcase
   end

   assign tmr_en     = (state_reg == S_WAIT_HIGH) || (state_reg == S_WAIT_LOW);
   assign db_level   = level_reg;
   assign db_rise    = rise_reg;
   assign db_fall    = fall_reg;
   assign toggle_out = toggle_reg;

endmodule

// File: tb/tb_debounce_fsm.sv
// Scoreboard bench for debounce_fsm with a behavioural 10-cycle timer.
import debounce_pkg::*;

module tb_debounce_fsm;

   logic clk = 1'b0;
   logic reset;
   logic btn_in;
   logic tick;
   logic tmr_en;
   logic db_level;
   logic db_rise;
   logic db_fall;
   logic toggle_out;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int tmr_cnt = 0;

   localparam int LAT_MIN = 34;
   localparam int LAT_MAX = 43;

   typedef struct {
      bit rise;
      bit level;
      bit toggle;
      int start;
   } exp_t;

   exp_t sb[$];

   debounce_fsm #(
      .STABLE_TICKS (4),
      .SYNC_STAGES  (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_in     (btn_in),
      .tick       (tick),
      .tmr_en     (tmr_en),
      .db_level   (db_level),
      .db_rise    (db_rise),
      .db_fall    (db_fall),
      .toggle_out (toggle_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Timer model (FINAL_VALUE=9): counts only while enabled, holds otherwise.
   always @(posedge clk) begin
      if (reset)       tmr_cnt <= 0;
      else if (tmr_en) tmr_cnt <= (tmr_cnt == 9) ? 0 : tmr_cnt + 1;
   end
   assign tick = tmr_en && (tmr_cnt == 9);

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor_step();
      exp_t e;
      int   lat;
      if (db_rise || db_fall) begin
         check("rise_fall_exclusive", int'(db_rise && db_fall), 0);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got rise=%0d fall=%0d, expected none (cycle %0d)",
                     db_rise, db_fall, cyc);
         end else begin
            e   = sb.pop_front();
            lat = cyc - e.start;
            $display("pulse rise=%0d fall=%0d level=%0d toggle=%0d latency=%0d cycle=%0d",
                     db_rise, db_fall, db_level, toggle_out, lat, cyc);
            check("pulse_is_rise", db_rise, e.rise);
            check("pulse_is_fall", db_fall, !e.rise);
            check("level_at_pulse", db_level, e.level);
            check("toggle_at_pulse", toggle_out, e.toggle);
            check("tmr_en_after_accept", tmr_en, 0);
            checks++;
            if (lat < LAT_MIN || lat > LAT_MAX) begin
               errors++;
               $display("FAIL pulse_latency: got %0d cycles, expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
            end
         end
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 80) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s: pending=%0d after 80 cycles, expected 0", name, sb.size());
         sb.delete();
      end
   endtask

   // Drive a settled level, queue the expected accepted edge and wait for it.
   task automatic settle(input bit val, input bit exp_toggle, input bit check_en, input string name);
      exp_t e;
      @(negedge clk);
      btn_in   = val;
      e.rise   = val;
      e.level  = val;
      e.toggle = exp_toggle;
      e.start  = cyc;
      sb.push_back(e);
      $display("drive %s btn_in=%0d cycle=%0d", name, val, cyc);
      if (check_en) begin
         repeat (2) @(negedge clk);
         check("tmr_en_before_wait", tmr_en, 0);
         @(negedge clk);
         check("tmr_en_in_wait", tmr_en, 1);
      end
      wait_drain(name);
      repeat (20) @(negedge clk);
   endtask

   task automatic stimulus();
      int n;
      reset  = 1'b1;
      btn_in = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_state", int'(dut.state_reg), int'(S_LOW));
      check("reset_cnt", int'(dut.cnt_reg), 0);
      check("reset_tmr_en", tmr_en, 0);
      check("reset_level", db_level, 0);
      check("reset_rise", db_rise, 0);
      check("reset_fall", db_fall, 0);
      check("reset_toggle", toggle_out, 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_tmr_en", tmr_en, 0);

      // Clean press and release.
      settle(1'b1, 1'b1, 1'b1, "clean_press");
      check("press_level_held", db_level, 1);
      settle(1'b0, 1'b1, 1'b0, "clean_release");
      check("release_level_held", db_level, 0);

      // Reset in S_WAIT_HIGH with cnt=3 clears everything including toggle.
      @(negedge clk);
      btn_in = 1'b1;
      n = 0;
      while (dut.cnt_reg != 2'd3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("reached_cnt3", int'(dut.cnt_reg), 3);
      reset  = 1'b1;
      btn_in = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_state", int'(dut.state_reg), int'(S_LOW));
      check("midreset_cnt", int'(dut.cnt_reg), 0);
      check("midreset_tmr_en", tmr_en, 0);
      check("midreset_level", db_level, 0);
      check("midreset_rise", db_rise, 0);
      check("midreset_toggle", toggle_out, 0);
      repeat (60) @(negedge clk);

      // Bounce: 8 phases of 7 cycles, then settle high.
      for (int i = 0; i < 8; i++) begin
         btn_in = (i % 2 == 0);
         repeat (7) @(negedge clk);
         if (i % 2 == 1) begin
            check("bounce_abort_state", int'(dut.state_reg), int'(S_LOW));
            check("bounce_abort_cnt", int'(dut.cnt_reg), 0);
         end
      end
      settle(1'b1, 1'b1, 1'b0, "bounce_press");
      settle(1'b0, 1'b1, 1'b0, "bounce_release");
      settle(1'b1, 1'b0, 1'b0, "second_press");
      settle(1'b0, 1'b0, 1'b0, "second_release");

      // Abort on the same edge as the third tick (cnt=2).
      @(negedge clk);
      btn_in = 1'b1;
      n = 0;
      while (!(dut.cnt_reg == 2'd2 && tmr_cnt == 7) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("collision_setup_cnt", int'(dut.cnt_reg), 2);
      btn_in = 1'b0;
      repeat (2) @(negedge clk);
      check("collision_tick_present", tick, 1);
      check("collision_state_before", int'(dut.state_reg), int'(S_WAIT_HIGH));
      @(negedge clk);
      check("collision_state", int'(dut.state_reg), int'(S_LOW));
      check("collision_cnt", int'(dut.cnt_reg), 0);
      check("collision_tmr_en", tmr_en, 0);
      check("collision_no_rise", db_rise, 0);
      check("collision_toggle", toggle_out, 0);
      repeat (30) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
   endtask

   initial begin
      fork
         begin
            forever begin
               @(negedge clk);
               monitor_step();
            end
         end
         begin
            stimulus();
         end
      join_any
      disable fork;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/debounce_fsm.md
Name: debounce_fsm

Overview:
- Debounce state machine that consumes the periodic `done` strobe of the parameterised timer and qualifies a raw push-button input.
- Drives the timer's `enable` so the timer counts only while an input transition is being qualified.
- Outputs are a clean debounced level, one-cycle rise and fall pulses, and a toggle level for the LED stage downstream.
- Sits between the board button pin and the toggle/LED logic in the button-toggle design.

Parameters:
- STABLE_TICKS, 4, number of consecutive timer ticks the synchronised input must hold before a transition is accepted; legal range 1..255.
- SYNC_STAGES, 2, depth of the input synchroniser; legal range 2..3.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_in  input  1  raw asynchronous button level.
- tick  input  1  one-cycle strobe from the timer's done output.
- tmr_en  output  1  enable to the timer; high only in the wait states.
- db_level  output  1  debounced button level.
- db_rise  output  1  one-cycle pulse when db_level goes 0->1.
- db_fall  output  1  one-cycle pulse when db_level goes 1->0.
- toggle_out  output  1  flips on every accepted rise.

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high. It has priority over all other inputs on the clock edge.
- Reset values: state=S_LOW, cnt=0, sync chain all 0, db_level=0, db_rise=0, db_fall=0, toggle_out=0, tmr_en=0.
- Synchroniser: btn_s is btn_in delayed by SYNC_STAGES flops. The FSM uses btn_s only.
- FSM state is registered with four states: S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW.
- tmr_en is decoded from the registered state: 1 in S_WAIT_HIGH and S_WAIT_LOW, else 0. No combinational path from btn_in or tick.
- S_LOW:
  - btn_s=1 -> S_WAIT_HIGH, cnt<=0.
  - Else stay.
  - tick is ignored.
- S_WAIT_HIGH:
  - btn_s=0 -> S_LOW, cnt<=0 (bounce abort).
  - Else if tick and cnt==STABLE_TICKS-1 -> S_HIGH; same edge db_level<=1, db_rise<=1, toggle_out<=~toggle_out, cnt<=0.
  - Else if tick -> cnt<=cnt+1.
  - Else hold.
- S_HIGH:
  - btn_s=0 -> S_WAIT_LOW, cnt<=0.
  - Else stay.
- S_WAIT_LOW: mirror of S_WAIT_HIGH with btn_s=1 as the abort condition. On acceptance -> S_LOW with db_level<=0, db_fall<=1. toggle_out is unchanged.
- Simultaneous events:
  - btn_s reverting on the same edge as a tick: the abort wins and the tick is not counted.
  - A tick while reset is high is ignored.
- Pulses: db_rise and db_fall are registered and high for exactly one cycle. They default to 0 every cycle not listed above and are never high together.
- cnt width is max(1, $clog2(STABLE_TICKS)). cnt never exceeds STABLE_TICKS-1; no wrap.
- Timer phase: the timer is not cleared by this block. The first counted tick may arrive anywhere within one timer period. Stable time before acceptance is therefore between (STABLE_TICKS-1) and STABLE_TICKS timer periods.
- Latency: btn_s lags btn_in by SYNC_STAGES cycles. Entry to a wait state takes one more cycle. The acceptance edge is the clk edge that samples the STABLE_TICKS-th tick. db_level, db_rise and toggle_out are valid the cycle after that edge.
- Reset mid-operation: a reset asserted in any wait state returns to S_LOW with all outputs at reset values on the next edge. There is no pending pulse.

Decomposition:
- Package debounce_pkg holds the state encoding localparams: S_LOW=2'd0, S_WAIT_HIGH=2'd1, S_HIGH=2'd2, S_WAIT_LOW=2'd3.
- One sub-module: sync_ff (parameter STAGES, ports clk, reset, d, q), instantiated once for btn_in.
- The timer is instantiated at top level beside this block, not inside it.

Test Plan:
- Common bench setup: STABLE_TICKS=4, SYNC_STAGES=2. The timer is instantiated with FINAL_VALUE=9, giving a tick every 10 cycles. The timer is fed tmr_en, and its done drives tick.
- Clean press: btn_in 0->1 held 100 cycles -> tmr_en=1 within 3 cycles; db_rise is a single pulse after 4 ticks; db_level=1; toggle_out=1; tmr_en=0 after acceptance.
- Bounce: btn_in toggles every 7 cycles for 60 cycles, then holds 1 -> no db_rise during bouncing; exactly one db_rise, about 4 tick periods after it settles; cnt reset on every abort.
- Release: from db_level=1, btn_in 1->0 held -> one db_fall pulse after 4 ticks; db_level=0; toggle_out unchanged.
- Two full press/release cycles -> toggle_out 0->1->1->0. db_rise and db_fall are never asserted together.
- Abort/tick collision: force btn_s to drop on the same edge as a tick in S_WAIT_HIGH with cnt=2 -> state=S_LOW, cnt=0, no db_rise.
- Reset in S_WAIT_HIGH with cnt=3 -> next edge: state=S_LOW, tmr_en=0, all outputs 0. A subsequent tick produces no pulse.
